// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at the tail, collects CDB/LSB results,
// and retires entries in program order, resolving branches and jalr at commit.
module reorder_buffer #(
    parameter int RoB_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,

    input  logic                 issue_en,
    input  logic [1:0]           issue_type,
    input  logic [4:0]           issue_rd,
    input  logic [31:0]          issue_pc,
    input  logic                 issue_pred_taken,
    input  logic [31:0]          issue_alt_pc,
    output logic [RoB_WIDTH-1:0] issue_tag,

    input  logic                 CDB_update_en,
    input  logic [RoB_WIDTH-1:0] CDB_update_index,
    input  logic [31:0]          CDB_update_data,
    input  logic                 LSB_update_en,
    input  logic [RoB_WIDTH-1:0] LSB_update_index,
    input  logic [31:0]          LSB_update_data,

    input  logic [RoB_WIDTH-1:0] query_j_index,
    input  logic [RoB_WIDTH-1:0] query_k_index,
    output logic                 query_j_ready,
    output logic                 query_k_ready,
    output logic [31:0]          query_j_data,
    output logic [31:0]          query_k_data,

    output logic                 commit_en,
    output logic [4:0]           commit_rd,
    output logic [31:0]          commit_data,
    output logic [RoB_WIDTH-1:0] commit_index,
    output logic                 store_commit_en,
    output logic                 flush_signal,
    output logic [31:0]          flush_pc,

    output logic                 isFull,
    output logic                 isEmpty
);

    localparam int RoB_SIZE = 1 << RoB_WIDTH;
    localparam logic [RoB_WIDTH:0] NON_DEP    = {1'b1, {RoB_WIDTH{1'b0}}};
    localparam logic [RoB_WIDTH:0] FULL_COUNT = {1'b1, {RoB_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_BRANCH = 2'd1,
        TYPE_STORE  = 2'd2,
        TYPE_JALR   = 2'd3
    } entry_type_e;

    logic [RoB_SIZE-1:0]  busy_q;
    logic [RoB_SIZE-1:0]  ready_q;
    logic [RoB_SIZE-1:0]  pred_q;
    entry_type_e          type_q  [RoB_SIZE];
    logic [4:0]           rd_q    [RoB_SIZE];
    logic [31:0]          pc_q    [RoB_SIZE];
    logic [31:0]          alt_q   [RoB_SIZE];
    logic [31:0]          value_q [RoB_SIZE];

    logic [RoB_WIDTH-1:0] head_q, head_d;
    logic [RoB_WIDTH-1:0] tail_q, tail_d;
    logic [RoB_WIDTH:0]   count_q, count_d;

    logic                 commit_en_q, commit_en_d;
    logic [4:0]           commit_rd_q;
    logic [31:0]          commit_data_q, commit_data_d;
    logic [RoB_WIDTH-1:0] commit_index_q;
    logic                 store_commit_en_q, store_commit_en_d;
    logic                 flush_signal_q, flush_signal_d;
    logic [31:0]          flush_pc_q, flush_pc_d;

    logic                 commit_fire;
    logic                 issue_fire;
    entry_type_e          head_type;

    assign isFull    = (count_q == FULL_COUNT);
    assign isEmpty   = (count_q == '0);
    assign issue_tag = tail_q;

    // Forwarding lookups see only pre-edge state; same-cycle CDB data is not bypassed.
    assign query_j_ready = busy_q[query_j_index] && ready_q[query_j_index]
                           && ({1'b0, query_j_index} != NON_DEP);
    assign query_k_ready = busy_q[query_k_index] && ready_q[query_k_index]
                           && ({1'b0, query_k_index} != NON_DEP);
    assign query_j_data  = value_q[query_j_index];
    assign query_k_data  = value_q[query_k_index];

    assign commit_en       = commit_en_q;
    assign commit_rd       = commit_rd_q;
    assign commit_data     = commit_data_q;
    assign commit_index    = commit_index_q;
    assign store_commit_en = store_commit_en_q;
    assign flush_signal    = flush_signal_q;
    assign flush_pc        = flush_pc_q;

    always_comb begin
        head_type         = type_q[head_q];
        commit_fire       = !flush_signal_q && busy_q[head_q] && ready_q[head_q];
        issue_fire        = !flush_signal_q && issue_en && !isFull;

        commit_en_d       = commit_fire && (rd_q[head_q] != 5'd0)
                            && (head_type == TYPE_REG || head_type == TYPE_JALR);
        store_commit_en_d = commit_fire && (head_type == TYPE_STORE);
        flush_signal_d    = commit_fire
                            && ((head_type == TYPE_BRANCH && value_q[head_q][0] != pred_q[head_q])
                                || head_type == TYPE_JALR);
        commit_data_d     = (head_type == TYPE_JALR) ? pc_q[head_q] + 32'd4 : value_q[head_q];
        flush_pc_d        = (head_type == TYPE_JALR) ? value_q[head_q] : alt_q[head_q];

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_signal_d) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit_fire) head_d = head_q + 1'b1;
            if (issue_fire)  tail_d = tail_q + 1'b1;
            case ({issue_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q            <= '0;
            ready_q           <= '0;
            pred_q            <= '0;
            for (int i = 0; i < RoB_SIZE; i++) begin
                type_q[i]  <= TYPE_REG;
                rd_q[i]    <= '0;
                pc_q[i]    <= '0;
                alt_q[i]   <= '0;
                value_q[i] <= '0;
            end
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            commit_en_q       <= 1'b0;
            commit_rd_q       <= '0;
            commit_data_q     <= '0;
            commit_index_q    <= '0;
            store_commit_en_q <= 1'b0;
            flush_signal_q    <= 1'b0;
            flush_pc_q        <= '0;
        end else if (!rdy_in) begin
            commit_en_q       <= 1'b0;
            store_commit_en_q <= 1'b0;
            flush_signal_q    <= 1'b0;
        end else begin
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            commit_en_q       <= commit_en_d;
            store_commit_en_q <= store_commit_en_d;
            flush_signal_q    <= flush_signal_d;

            if (commit_fire) begin
                commit_rd_q    <= rd_q[head_q];
                commit_index_q <= head_q;
                commit_data_q  <= commit_data_d;
            end
            if (flush_signal_d) begin
                flush_pc_q <= flush_pc_d;
            end

            if (flush_signal_d) begin
                busy_q  <= '0;
                ready_q <= '0;
            end else if (!flush_signal_q) begin
                // LSB is applied first so that CDB wins on a same-index collision.
                if (LSB_update_en && busy_q[LSB_update_index]) begin
                    ready_q[LSB_update_index] <= 1'b1;
                    value_q[LSB_update_index] <= LSB_update_data;
                end
                if (CDB_update_en && busy_q[CDB_update_index]) begin
                    ready_q[CDB_update_index] <= 1'b1;
                    value_q[CDB_update_index] <= CDB_update_data;
                end
                if (commit_fire) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                end
                if (issue_fire) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    pred_q[tail_q]  <= issue_pred_taken;
                    type_q[tail_q]  <= entry_type_e'(issue_type);
                    rd_q[tail_q]    <= issue_rd;
                    pc_q[tail_q]    <= issue_pc;
                    alt_q[tail_q]   <= issue_alt_pc;
                end
            end
        end
    end

endmodule
